// File: rtl/mod_cache_arbiter.sv
// mod_cache_arbiter: round-robin arbiter between the L1 icache and dcache that
// issues block reads and writebacks on the 64-bit system bus. Read beats are
// gathered into one block and returned to the requesting cache; writeback blocks
// are serialized into data beats.
module mod_cache_arbiter #(
  parameter int unsigned WORDSIZE  = 64,
  parameter int unsigned BLOCKBITS = 512,
  parameter int unsigned TAGWIDTH  = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORDSIZE-1:0]  ic_req,
  input  logic [TAGWIDTH-1:0]  ic_reqtag,
  input  logic                 ic_reqcyc,
  output logic                 ic_reqack,
  output logic [BLOCKBITS-1:0] ic_resp,
  output logic [TAGWIDTH-1:0]  ic_resptag,
  output logic                 ic_respcyc,
  input  logic                 ic_respack,
  input  logic [WORDSIZE-1:0]  dc_req,
  input  logic [TAGWIDTH-1:0]  dc_reqtag,
  input  logic                 dc_reqcyc,
  output logic                 dc_reqack,
  output logic [BLOCKBITS-1:0] dc_resp,
  output logic [TAGWIDTH-1:0]  dc_resptag,
  output logic                 dc_respcyc,
  input  logic                 dc_respack,
  input  logic [BLOCKBITS-1:0] dc_wdata,
  output logic [WORDSIZE-1:0]  bus_req,
  output logic [TAGWIDTH-1:0]  bus_reqtag,
  output logic                 bus_reqcyc,
  input  logic                 bus_reqack,
  input  logic [WORDSIZE-1:0]  bus_resp,
  input  logic [TAGWIDTH-1:0]  bus_resptag,
  input  logic                 bus_respcyc,
  output logic                 bus_respack
);

  localparam int unsigned BEATS = BLOCKBITS / WORDSIZE;
  localparam int unsigned CW    = $clog2(BEATS);
  localparam logic [CW-1:0]       LAST_BEAT   = CW'(BEATS - 1);
  localparam logic [WORDSIZE-1:0] OFFSET_MASK = WORDSIZE'(BLOCKBITS / 8 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WDATA,
    S_COLLECT,
    S_DELIVER
  } state_t;

  state_t               state, state_d;
  logic [CW-1:0]        k, k_d;
  logic                 last_dc, last_dc_d;   // dcache held the most recent grant
  logic                 gnt_dc, gnt_dc_d;     // current transaction belongs to dcache
  logic                 is_wr, is_wr_d;
  logic [BLOCKBITS-1:0] wbuf, wbuf_d;
  logic [BLOCKBITS-1:0] blk, blk_d;
  logic [TAGWIDTH-1:0]  rtag, rtag_d;
  logic                 ic_reqack_d, dc_reqack_d;
  logic                 ic_respcyc_d, dc_respcyc_d;
  logic                 bus_reqcyc_d;
  logic [WORDSIZE-1:0]  bus_req_d;
  logic [TAGWIDTH-1:0]  bus_reqtag_d;
  logic                 pick_dc;

  // Tie goes to the cache that did not win last time
  assign pick_dc = dc_reqcyc & (~ic_reqcyc | ~last_dc);

  // Both caches see the same assembled block; only respcyc tells them apart
  assign ic_resp    = blk;
  assign dc_resp    = blk;
  assign ic_resptag = rtag;
  assign dc_resptag = rtag;

  // Beats are only accepted while gathering a read block
  assign bus_respack = (state == S_COLLECT) & bus_respcyc;

  // Next-state and next-output computation; all outputs below are registered
  always_comb begin
    state_d      = state;
    k_d          = k;
    last_dc_d    = last_dc;
    gnt_dc_d     = gnt_dc;
    is_wr_d      = is_wr;
    wbuf_d       = wbuf;
    blk_d        = blk;
    rtag_d       = rtag;
    ic_reqack_d  = 1'b0;
    dc_reqack_d  = 1'b0;
    ic_respcyc_d = ic_respcyc;
    dc_respcyc_d = dc_respcyc;
    bus_reqcyc_d = bus_reqcyc;
    bus_req_d    = bus_req;
    bus_reqtag_d = bus_reqtag;
    case (state)
      S_IDLE: begin
        bus_req_d    = '0;
        bus_reqtag_d = '0;
        bus_reqcyc_d = 1'b0;
        if (ic_reqcyc | dc_reqcyc) begin
          state_d      = S_ISSUE;
          bus_reqcyc_d = 1'b1;
          gnt_dc_d     = pick_dc;
          last_dc_d    = pick_dc;
          if (pick_dc) begin
            dc_reqack_d  = 1'b1;
            bus_req_d    = dc_req & ~OFFSET_MASK;
            bus_reqtag_d = dc_reqtag;
            is_wr_d      = ~dc_reqtag[TAGWIDTH-1];
            wbuf_d       = dc_wdata;
          end else begin
            ic_reqack_d  = 1'b1;
            bus_req_d    = ic_req & ~OFFSET_MASK;
            bus_reqtag_d = ic_reqtag;
            is_wr_d      = 1'b0;
          end
        end
      end
      S_ISSUE: begin
        if (bus_reqack) begin
          bus_reqcyc_d = 1'b0;
          bus_reqtag_d = '0;
          if (is_wr) begin
            // beat 0 goes out with the ack, so the counter starts at 1 and the
            // block is idle again while beat 7 is still on the bus
            state_d   = S_WDATA;
            bus_req_d = wbuf[WORDSIZE-1:0];
            k_d       = CW'(1);
          end else begin
            state_d   = S_COLLECT;
            bus_req_d = '0;
            k_d       = '0;
          end
        end
      end
      S_WDATA: begin
        bus_req_d = wbuf[k*WORDSIZE +: WORDSIZE];
        k_d       = k + 1'b1;
        if (k == LAST_BEAT) state_d = S_IDLE;
      end
      S_COLLECT: begin
        if (bus_respcyc) begin
          blk_d[k*WORDSIZE +: WORDSIZE] = bus_resp;
          if (k == '0) rtag_d = bus_resptag;
          k_d = k + 1'b1;
          if (k == LAST_BEAT) begin
            state_d = S_DELIVER;
            if (gnt_dc) dc_respcyc_d = 1'b1;
            else        ic_respcyc_d = 1'b1;
          end
        end
      end
      S_DELIVER: begin
        if (gnt_dc ? dc_respack : ic_respack) begin
          ic_respcyc_d = 1'b0;
          dc_respcyc_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      k          <= '0;
      last_dc    <= 1'b1;
      gnt_dc     <= 1'b0;
      is_wr      <= 1'b0;
      wbuf       <= '0;
      blk        <= '0;
      rtag       <= '0;
      ic_reqack  <= 1'b0;
      dc_reqack  <= 1'b0;
      ic_respcyc <= 1'b0;
      dc_respcyc <= 1'b0;
      bus_reqcyc <= 1'b0;
      bus_req    <= '0;
      bus_reqtag <= '0;
    end else begin
      state      <= state_d;
      k          <= k_d;
      last_dc    <= last_dc_d;
      gnt_dc     <= gnt_dc_d;
      is_wr      <= is_wr_d;
      wbuf       <= wbuf_d;
      blk        <= blk_d;
      rtag       <= rtag_d;
      ic_reqack  <= ic_reqack_d;
      dc_reqack  <= dc_reqack_d;
      ic_respcyc <= ic_respcyc_d;
      dc_respcyc <= dc_respcyc_d;
      bus_reqcyc <= bus_reqcyc_d;
      bus_req    <= bus_req_d;
      bus_reqtag <= bus_reqtag_d;
    end
  end

endmodule

// File: tb/tb_mod_cache_arbiter.sv
// Testbench for mod_cache_arbiter: directed scenarios plus randomized traffic.
// The stimulus process plays both caches and the system bus on a fixed schedule
// and publishes per-cycle expectations; a negedge process compares against them.
module tb_mod_cache_arbiter;
  localparam int W = 64;
  localparam int B = 512;
  localparam int T = 13;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] ic_req, dc_req, bus_req, bus_resp;
  logic [T-1:0] ic_reqtag, dc_reqtag, ic_resptag, dc_resptag, bus_reqtag, bus_resptag;
  logic         ic_reqcyc, ic_reqack, ic_respcyc, ic_respack;
  logic         dc_reqcyc, dc_reqack, dc_respcyc, dc_respack;
  logic [B-1:0] ic_resp, dc_resp, dc_wdata;
  logic         bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;

  always #5 clk = ~clk;

  mod_cache_arbiter #(.WORDSIZE(W), .BLOCKBITS(B), .TAGWIDTH(T)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_reqtag(ic_reqtag), .ic_reqcyc(ic_reqcyc), .ic_reqack(ic_reqack),
    .ic_resp(ic_resp), .ic_resptag(ic_resptag), .ic_respcyc(ic_respcyc), .ic_respack(ic_respack),
    .dc_req(dc_req), .dc_reqtag(dc_reqtag), .dc_reqcyc(dc_reqcyc), .dc_reqack(dc_reqack),
    .dc_resp(dc_resp), .dc_resptag(dc_resptag), .dc_respcyc(dc_respcyc), .dc_respack(dc_respack),
    .dc_wdata(dc_wdata),
    .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack),
    .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respcyc(bus_respcyc), .bus_respack(bus_respack)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          cyc = 0;
  always @(posedge clk) cyc++;

  task automatic cmp(input string nm, input logic [B-1:0] act, input logic [B-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Expectations for the current cycle
  bit           chk_en = 1'b0;
  bit           e_ic_reqack, e_dc_reqack, e_bus_reqcyc, e_ic_respcyc, e_dc_respcyc;
  bit           e_collect, e_chk_req, e_zero;
  logic [W-1:0] e_bus_req;
  logic [T-1:0] e_bus_reqtag, e_resptag;
  logic [B-1:0] e_resp;

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("ic_reqack", B'(ic_reqack), B'(e_ic_reqack));
      cmp("dc_reqack", B'(dc_reqack), B'(e_dc_reqack));
      cmp("bus_reqcyc", B'(bus_reqcyc), B'(e_bus_reqcyc));
      cmp("ic_respcyc", B'(ic_respcyc), B'(e_ic_respcyc));
      cmp("dc_respcyc", B'(dc_respcyc), B'(e_dc_respcyc));
      cmp("bus_respack", B'(bus_respack), B'(e_collect ? bus_respcyc : 1'b0));
      if (e_chk_req) cmp("bus_req", B'(bus_req), B'(e_bus_req));
      if (e_bus_reqcyc) cmp("bus_reqtag", B'(bus_reqtag), B'(e_bus_reqtag));
      if (e_ic_respcyc) begin
        cmp("ic_resp", ic_resp, e_resp);
        cmp("ic_resptag", B'(ic_resptag), B'(e_resptag));
      end
      if (e_dc_respcyc) begin
        cmp("dc_resp", dc_resp, e_resp);
        cmp("dc_resptag", B'(dc_resptag), B'(e_resptag));
      end
      if (e_zero) begin
        cmp("zero_bus_req", B'(bus_req), '0);
        cmp("zero_bus_reqtag", B'(bus_reqtag), '0);
        cmp("zero_ic_resp", ic_resp, '0);
        cmp("zero_dc_resp", dc_resp, '0);
        cmp("zero_resptags", B'({ic_resptag, dc_resptag}), '0);
      end
    end
  end

  // Cache-side request state and round-robin history of the reference model
  bit           ic_pend, dc_pend, last_dc, rnd_mode;
  logic [W-1:0] ic_a, dc_a;
  logic [T-1:0] ic_t, dc_t;
  logic [B-1:0] dc_w;

  // Observations captured for the literal checks
  int           t_grant, t_resp;
  logic [W-1:0] cap_req;
  logic         cap_gnt_dc;
  logic [B-1:0] cap_resp, lit_blk;
  logic [T-1:0] cap_rtag;
  logic [W-1:0] cap_w [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    e_ic_reqack = 0; e_dc_reqack = 0; e_bus_reqcyc = 0;
    e_ic_respcyc = 0; e_dc_respcyc = 0;
    e_collect = 0; e_chk_req = 0; e_zero = 0;
  endtask

  task automatic stray();
    bus_respcyc = ($urandom_range(0, 3) == 0);
    bus_resp    = {$urandom, $urandom};
    bus_resptag = 13'($urandom);
  endtask

  function automatic logic [B-1:0] rand_blk();
    logic [B-1:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive_reqs();
    ic_reqcyc = ic_pend; ic_req = ic_a; ic_reqtag = ic_t;
    dc_reqcyc = dc_pend; dc_req = dc_a; dc_reqtag = dc_t; dc_wdata = dc_w;
  endtask

  task automatic post_ic(input logic [W-1:0] a, input logic [T-1:0] t);
    ic_pend = 1; ic_a = a; ic_t = t;
    drive_reqs();
  endtask

  task automatic post_dc(input logic [W-1:0] a, input logic [T-1:0] t, input logic [B-1:0] w);
    dc_pend = 1; dc_a = a; dc_t = t; dc_w = w;
    drive_reqs();
  endtask

  task automatic rand_ic();
    post_ic({$urandom, $urandom}, {1'b1, 12'($urandom)});
  endtask

  task automatic rand_dc();
    post_dc({$urandom, $urandom}, 13'($urandom), rand_blk());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      stray();
      tick();
      set_idle_exp();
    end
  endtask

  // One complete transaction: the grant happens at the next edge.
  // gapmode: 0 no gaps/beat k = k, 1 random gaps and data, 2 beats 3 and 6 late by 2.
  // abort_at: beat index after which reset is applied (-1 = none).
  task automatic run_txn(input int ackd, input int gapmode, input int abort_at);
    bit           g, wr;
    int           gap, hold;
    logic [W-1:0] a, beat;
    logic [T-1:0] t;
    logic [B-1:0] w, blk;
    g = dc_pend && (!ic_pend || !last_dc);
    last_dc = g;
    if (g) begin a = dc_a; t = dc_t; w = dc_w; wr = !dc_t[T-1]; end
    else   begin a = ic_a; t = ic_t; w = '0;   wr = 1'b0;       end
    blk = '0;
    tick();
    t_grant = cyc;
    set_idle_exp();
    e_ic_reqack = !g; e_dc_reqack = g; e_bus_reqcyc = 1; e_chk_req = 1;
    e_bus_req = {a[W-1:6], 6'b0}; e_bus_reqtag = t;
    cap_req = bus_req; cap_gnt_dc = dc_reqack;
    if (g) dc_pend = 0; else ic_pend = 0;
    drive_reqs();
    bus_reqack = 0;
    stray();
    for (int i = 0; i < ackd; i++) begin
      tick();
      e_ic_reqack = 0; e_dc_reqack = 0;
      stray();
    end
    bus_reqack = 1;
    tick();
    bus_reqack = 0;
    e_ic_reqack = 0; e_dc_reqack = 0; e_bus_reqcyc = 0; e_chk_req = 0;
    if (wr) begin
      for (int k = 0; k < 8; k++) begin
        e_chk_req = 1; e_bus_req = w[64*k +: 64];
        cap_w[k] = bus_req;
        stray();
        if (k < 7) tick();
      end
      return;
    end
    e_collect = 1;
    bus_respcyc = 0;
    for (int k = 0; k < 8; k++) begin
      if (gapmode == 1) gap = $urandom_range(0, 2);
      else if (gapmode == 2 && (k == 3 || k == 6)) gap = 2;
      else gap = 0;
      for (int i = 0; i < gap; i++) begin
        bus_respcyc = 0; bus_resp = {$urandom, $urandom};
        tick();
      end
      beat = (gapmode == 1) ? {$urandom, $urandom} : 64'(k);
      blk[64*k +: 64] = beat;
      bus_respcyc = 1; bus_resp = beat;
      bus_resptag = (k == 0 || gapmode != 1) ? t : 13'($urandom);
      tick();
      if (k == abort_at) begin
        bus_respcyc = 0;
        reset = 1;
        tick();
        reset = 0;
        set_idle_exp();
        e_zero = 1;
        last_dc = 1; ic_pend = 0; dc_pend = 0;
        drive_reqs();
        // the rest of the abandoned burst still arrives and must be ignored
        for (int j = k + 1; j < 8; j++) begin
          bus_respcyc = 1; bus_resp = {$urandom, $urandom}; bus_resptag = t;
          tick();
        end
        bus_respcyc = 0;
        tick();
        e_zero = 0;
        return;
      end
    end
    bus_respcyc = 0;
    e_collect = 0;
    e_ic_respcyc = !g; e_dc_respcyc = g; e_resp = blk; e_resptag = t;
    t_resp = cyc;
    cap_resp = g ? dc_resp : ic_resp;
    cap_rtag = g ? dc_resptag : ic_resptag;
    hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) begin
      stray();
      if (rnd_mode && !ic_pend && $urandom_range(0, 1) == 0) rand_ic();
      if (rnd_mode && !dc_pend && $urandom_range(0, 1) == 0) rand_dc();
      tick();
    end
    stray();
    if (g) dc_respack = 1; else ic_respack = 1;
    tick();
    ic_respack = 0; dc_respack = 0;
    e_ic_respcyc = 0; e_dc_respcyc = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    set_idle_exp();
    e_zero = 1;
    reset = 0;
    last_dc = 1;
    tick();
    e_zero = 0;
  endtask

  initial begin
    logic [B-1:0] wblk;
    reset = 1;
    ic_req = '0; ic_reqtag = '0; ic_reqcyc = 0; ic_respack = 0;
    dc_req = '0; dc_reqtag = '0; dc_reqcyc = 0; dc_respack = 0; dc_wdata = '0;
    bus_reqack = 0; bus_resp = '0; bus_resptag = '0; bus_respcyc = 0;
    ic_pend = 0; dc_pend = 0; last_dc = 1; rnd_mode = 0;
    ic_a = '0; dc_a = '0; ic_t = '0; dc_t = '0; dc_w = '0;
    set_idle_exp();
    e_bus_req = '0; e_bus_reqtag = '0; e_resptag = '0; e_resp = '0;
    for (int k = 0; k < 8; k++) lit_blk[64*k +: 64] = 64'(k);

    tick();
    chk_en = 1;
    e_zero = 1;
    tick();
    reset = 0;
    tick();
    tick();
    e_zero = 0;

    // single icache read, minimum latency
    post_ic(64'h1000_0047, 13'h1001);
    run_txn(0, 0, -1);
    cmp("t1_bus_req", B'(cap_req), B'(64'h1000_0040));
    cmp("t1_resptag", B'(cap_rtag), B'(13'h1001));
    cmp("t1_block", cap_resp, lit_blk);
    cmp("t1_latency", B'(t_resp - t_grant), B'(9));

    // simultaneous requests from reset alternate icache, dcache, icache, dcache
    do_reset();
    for (int r = 0; r < 4; r++) begin
      if (!ic_pend) post_ic({$urandom, $urandom}, {1'b1, 12'($urandom)});
      if (!dc_pend) post_dc({$urandom, $urandom}, {1'b1, 12'($urandom)}, rand_blk());
      run_txn(0, 0, -1);
      cmp("tie_grant_dc", B'(cap_gnt_dc), B'(r % 2));
    end
    run_txn(0, 0, -1);

    // dcache writeback, words 0xA0..0xA7
    for (int k = 0; k < 8; k++) wblk[64*k +: 64] = 64'(8'hA0 + k);
    post_dc(64'h2000_0080, 13'h0001, wblk);
    run_txn(2, 0, -1);
    cmp("wr_beat0", B'(cap_w[0]), B'(64'hA0));
    cmp("wr_beat7", B'(cap_w[7]), B'(64'hA7));
    idle(10);

    // beats 3 and 6 each arrive two cycles late
    post_ic({$urandom, $urandom}, 13'h1234);
    run_txn(1, 2, -1);
    cmp("gap_block", cap_resp, lit_blk);
    cmp("gap_latency", B'(t_resp - t_grant), B'(14));

    // bus_reqack held off for 5 cycles
    post_dc(64'h0000_0000_dead_beef, 13'h1777, rand_blk());
    run_txn(5, 0, -1);
    cmp("ackwait_latency", B'(t_resp - t_grant), B'(14));
    cmp("ackwait_bus_req", B'(cap_req), B'(64'h0000_0000_dead_bec0));

    // reset after beat 4, then a fresh read
    post_ic({$urandom, $urandom}, 13'h1abc);
    run_txn(0, 0, 4);
    post_ic(64'h3000_0010, 13'h1002);
    run_txn(0, 0, -1);
    cmp("post_reset_block", cap_resp, lit_blk);
    cmp("post_reset_tag", B'(cap_rtag), B'(13'h1002));
    cmp("post_reset_latency", B'(t_resp - t_grant), B'(9));

    // randomized traffic
    rnd_mode = 1;
    for (int n = 0; n < 60; n++) begin
      if (!ic_pend && !dc_pend) begin
        idle($urandom_range(0, 2));
        case ($urandom_range(0, 2))
          0: rand_ic();
          1: rand_dc();
          default: begin rand_ic(); rand_dc(); end
        endcase
      end
      run_txn($urandom_range(0, 4), 1, -1);
    end
    rnd_mode = 0;
    while (ic_pend || dc_pend) run_txn(0, 1, -1);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
